fpu_core: RTL and testbench
===========================

Name: fpu_core

Overview:
- Single-precision IEEE-754 arithmetic unit: add, subtract, multiply and (optionally) divide, with all four rounding modes and eight exception flags.
- Fully pipelined; accepts one operation per clock.
- Sits behind the team's fpu_interface bundle:
  - inputs: opa, opb, rmode, fpu_op
  - outputs: out, inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero
- Results feed the transactor's 5-byte output element {flag_vector, result}.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 (binary32) is supported.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opa  input  32  operand A, binary32.
- opb  input  32  operand B, binary32.
- rmode  input  2  rounding mode: 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf.
- fpu_op  input  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4-7 reserved.
- out  output  32  result, binary32.
- inf  output  1  result is ±infinity.
- snan  output  1  opa or opb is a signalling NaN.
- qnan  output  1  result is NaN.
- ine  output  1  result is inexact.
- overflow  output  1  rounded result exceeded max finite.
- underflow  output  1  nonzero result below min normal; flushed to zero.
- zero  output  1  result is ±0.
- div_by_zero  output  1  finite nonzero / zero.

Behaviour:
- Reset: asserting reset low clears all pipeline registers immediately. out=0x00000000; all flags 0. This holds while reset is low, including mid-operation; in-flight ops are discarded.
- Pipeline: stage 1 registers opa/opb/rmode/fpu_op on a rising edge. Stage 2 registers out and flags on the next edge. Latency is 2 edges, throughput 1 op/cycle. There is no handshake; a new op every cycle is legal.
- Flag vector order used by the transactor (MSB..LSB): inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero.
- Denormals: denormal inputs are treated as ±0 with the sign kept. Tiny results are flushed to ±0 with underflow=1, ine=1, zero=1.
- Rounding: guard, round and sticky bits drive the rounding decision. Mantissa carry-out after rounding increments the exponent.
- Overflow result by rounding mode (overflow=1 and ine=1 in all cases):
  - rmode 0: ±inf.
  - rmode 1: ±0x7F7FFFFF.
  - rmode 2: positive→+inf, negative→0xFF7FFFFF.
  - rmode 3: negative→-inf, positive→0x7F7FFFFF.
  - inf=1 only when the delivered result is infinite.
- Add/sub: sub is add with opb's sign inverted.
  - Exact zero result is +0, except in rmode 3 where it is -0.
  - (-0)+(-0) gives -0.
  - inf-inf gives qNaN.
- Mul:
  - Result sign is the XOR of the operand signs.
  - 0×inf gives qNaN.
  - inf×finite-nonzero gives inf with no overflow flag.
- Div (op 3, when enabled):
  - 0/0 and inf/inf give qNaN.
  - finite-nonzero/0 gives signed inf with div_by_zero=1.
  - x/inf gives ±0.
- NaN handling:
  - Any NaN result is the canonical qNaN 0x7FC00000 with qnan=1.
  - A NaN input propagates as canonical qNaN.
  - snan=1 whenever either input has exponent 0xFF, a nonzero fraction and fraction bit 22 = 0.
- Reserved opcodes 4-7: out=0x7FC00000, qnan=1, other flags 0.
- Infinite or NaN results never set zero. Exact results never set ine.

Optional Feature:
- FPU_DIV_EN: when defined, op 3 performs division with full rounding and flags, using a restoring or non-restoring quotient loop of at least 26 quotient bits.
- When undefined, no divider logic is built, op 3 behaves as a reserved opcode (0x7FC00000, qnan=1), and div_by_zero is tied to 0.

Test Plan:
- Reset: drive reset low mid-stream with ops flowing → out=0x00000000 and all flags 0 immediately. After release, the first valid result appears 2 edges after the first operand is presented.
- Add/mul basics:
  - 0x3F800000+0x40000000, rmode 0 → 0x40400000, flags 0.
  - 0x40400000×0x3F000000 → 0x3FC00000.
  - 0x3F800000-0x3F800000, rmode 3 → 0x80000000, zero=1.
- Rounding:
  - 0x3F800000+0x33800000, rmode 0 → 0x3F800000, ine=1.
  - Same operands, rmode 2 → 0x3F800001, ine=1.
- Overflow:
  - 0x7F7FFFFF×0x40000000, rmode 0 → 0x7F800000, inf=1, overflow=1, ine=1.
  - Same operands, rmode 1 → 0x7F7FFFFF, overflow=1, ine=1, inf=0.
- NaN cases:
  - 0x7F800001+0x3F800000 → 0x7FC00000, snan=1, qnan=1.
  - 0x7F800000-0x7F800000 → 0x7FC00000, qnan=1, snan=0.
- Divide:
  - With FPU_DIV_EN: 0x3F800000/0x00000000 → 0x7F800000, inf=1, div_by_zero=1.
  - With FPU_DIV_EN: 0x40C00000/0x40000000 → 0x40400000.
  - Without FPU_DIV_EN: op 3 → 0x7FC00000, qnan=1.

Source files
------------

// File: rtl/fpu_core.sv
// fpu_core: two-stage single-precision (binary32) add/sub/mul/div unit.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears both pipeline stages
//   opa, opb     binary32 operands
//   rmode        0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf
//   fpu_op       0 add, 1 sub, 2 mul, 3 div, 4-7 reserved (canonical qNaN)
//   out          binary32 result
//   inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero
//                result flags, registered alongside out
//
// Interface timing: there is no handshake. Whatever sits on the inputs at a
// rising edge is one operation; its result and flags appear on the outputs
// after the following rising edge (2-edge latency, one op per cycle).
//
// Build option: define FPU_DIV_EN to build the divider. Without it op 3 is
// a reserved opcode and div_by_zero is constant 0.
//
// Denormal inputs are read as signed zero; tiny results flush to signed zero.
module fpu_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  input  logic [1:0]            rmode,
  input  logic [2:0]            fpu_op,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  inf,
  output logic                  snan,
  output logic                  qnan,
  output logic                  ine,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  zero,
  output logic                  div_by_zero
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] res;
    logic        inf;
    logic        ine;
    logic        ovf;
    logic        unf;
    logic        zero;
  } pack_t;

  // Round a normalised mantissa and pack it. m[26] is the hidden one,
  // m[25:3] the fraction, m[2] guard, m[1] round, m[0] sticky.
  function automatic pack_t round_pack(input logic              sign,
                                       input logic signed [9:0] e,
                                       input logic [26:0]       m,
                                       input logic [1:0]        rm);
    pack_t              p;
    logic               inexact;
    logic               up;
    logic               sat;
    logic [24:0]        sum;
    logic [22:0]        frac;
    logic signed [9:0]  e2;
    p       = '0;
    inexact = |m[2:0];
    case (rm)
      2'd0:    up = m[2] & (m[1] | m[0] | m[3]);
      2'd1:    up = 1'b0;
      2'd2:    up = inexact & ~sign;
      default: up = inexact & sign;
    endcase
    sum = {1'b0, m[26:3]} + {24'b0, up};
    // Carry out of the mantissa: 1.111..1 rounded up to 10.000..0.
    if (sum[24]) begin
      frac = sum[23:1];
      e2   = e + 10'sd1;
    end else begin
      frac = sum[22:0];
      e2   = e;
    end
    if (e2 >= 10'sd255) begin
      // Modes that round toward zero for this sign saturate to max finite.
      sat   = (rm == 2'd1) | ((rm == 2'd2) & sign) | ((rm == 2'd3) & ~sign);
      p.res = sat ? {sign, 8'hFE, 23'h7F_FFFF} : {sign, 8'hFF, 23'h0};
      p.inf = ~sat;
      p.ovf = 1'b1;
      p.ine = 1'b1;
    end else if (e2 <= 10'sd0) begin
      p.res  = {sign, 31'b0};
      p.unf  = 1'b1;
      p.ine  = 1'b1;
      p.zero = 1'b1;
    end else begin
      p.res = {sign, e2[7:0], frac};
      p.ine = inexact;
    end
    return p;
  endfunction

  // ---------------- stage 1: operand registers ----------------
  logic [31:0] opa_d, opa_q, opb_d, opb_q;
  logic [1:0]  rm_d, rm_q;
  logic [2:0]  op_d, op_q;

  always_comb begin
    opa_d = opa;
    opb_d = opb;
    rm_d  = rmode;
    op_d  = fpu_op;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_q <= '0;
      opb_q <= '0;
      rm_q  <= '0;
      op_q  <= '0;
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
      rm_q  <= rm_d;
      op_q  <= op_d;
    end
  end

  // ---------------- operand classification ----------------
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic [23:0] a_man, b_man;
  logic        a_zero, a_inf, a_nan, a_snan;
  logic        b_zero, b_inf, b_nan, b_snan;

  assign a_sign = opa_q[31];
  assign a_exp  = opa_q[30:23];
  assign a_frac = opa_q[22:0];
  assign b_sign = opb_q[31];
  assign b_exp  = opb_q[30:23];
  assign b_frac = opb_q[22:0];
  assign a_man  = {1'b1, a_frac};
  assign b_man  = {1'b1, b_frac};
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'h0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'h0);
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'h0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'h0);
  assign a_snan = a_nan && !a_frac[22];
  assign b_snan = b_nan && !b_frac[22];

  // ---------------- add / sub datapath ----------------
  logic              b_sign_eff, a_ge, eff_sub, lz_found, add_cancel;
  logic              big_sign;
  logic [7:0]        big_exp, small_exp, exp_diff;
  logic [4:0]        shamt, lz;
  logic [26:0]       big_w, small_w, aligned, diff_w, add_m;
  logic [53:0]       align_tmp;
  logic [27:0]       sum_w;
  logic signed [9:0] add_e;
  pack_t             add_p;

  always_comb begin
    b_sign_eff = b_sign ^ op_q[0];  // sub flips opb's sign
    a_ge       = {a_exp, a_frac} >= {b_exp, b_frac};
    big_sign   = a_ge ? a_sign : b_sign_eff;
    big_exp    = a_ge ? a_exp : b_exp;
    small_exp  = a_ge ? b_exp : a_exp;
    big_w      = a_ge ? {a_man, 3'b000} : {b_man, 3'b000};
    small_w    = a_ge ? {b_man, 3'b000} : {a_man, 3'b000};
    exp_diff   = big_exp - small_exp;
    // Past 27 places the small operand is pure sticky, so 31 is enough.
    shamt      = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
    align_tmp  = {small_w, 27'b0} >> shamt;
    aligned    = {align_tmp[53:28], align_tmp[27] | (|align_tmp[26:0])};
    eff_sub    = a_sign ^ b_sign_eff;
    sum_w      = '0;
    diff_w     = '0;
    lz         = '0;
    lz_found   = 1'b0;
    add_cancel = 1'b0;
    if (!eff_sub) begin
      sum_w = {1'b0, big_w} + {1'b0, aligned};
      if (sum_w[27]) begin
        add_m = {sum_w[27:2], sum_w[1] | sum_w[0]};
        add_e = $signed({2'b00, big_exp}) + 10'sd1;
      end else begin
        add_m = sum_w[26:0];
        add_e = $signed({2'b00, big_exp});
      end
    end else begin
      diff_w     = big_w - aligned;
      add_cancel = (diff_w == 27'h0);
      for (int i = 26; i >= 0; i--) begin
        if (!lz_found && diff_w[i]) begin
          lz       = 5'(26 - i);
          lz_found = 1'b1;
        end
      end
      add_m = diff_w << lz;
      add_e = $signed({2'b00, big_exp}) - $signed({5'b00000, lz});
    end
    add_p = round_pack(big_sign, add_e, add_m, rm_q);
  end

  // ---------------- multiply datapath ----------------
  logic [47:0]       prod;
  logic [26:0]       mul_m;
  logic signed [9:0] mul_e;
  logic              mul_sign;
  pack_t             mul_p;

  always_comb begin
    mul_sign = a_sign ^ b_sign;
    prod     = 48'(a_man) * 48'(b_man);
    if (prod[47]) begin
      mul_m = {prod[47:22], |prod[21:0]};
      mul_e = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd126;
    end else begin
      mul_m = {prod[46:21], |prod[20:0]};
      mul_e = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
    end
    mul_p = round_pack(mul_sign, mul_e, mul_m, rm_q);
  end

`ifdef FPU_DIV_EN
  // ---------------- divide datapath (restoring, 27 quotient bits) ----------------
  logic [25:0]       rem;
  logic [26:0]       quo;
  logic [26:0]       div_m;
  logic signed [9:0] div_e;
  pack_t             div_p;

  always_comb begin
    rem = {2'b00, a_man};
    quo = '0;
    for (int i = 26; i >= 0; i--) begin
      if (rem >= {2'b00, b_man}) begin
        quo[i] = 1'b1;
        rem    = rem - {2'b00, b_man};
      end
      rem = rem << 1;
    end
    // Mantissa ratio lies in (0.5, 2): the quotient's top bit is 26 or 25.
    if (quo[26]) begin
      div_m = {quo[26:1], quo[0] | (rem != 26'h0)};
      div_e = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
    end else begin
      div_m = {quo[25:0], rem != 26'h0};
      div_e = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd126;
    end
    div_p = round_pack(mul_sign, div_e, div_m, rm_q);
  end
`endif

  // ---------------- special-case selection ----------------
  logic [31:0] out_d, out_q;
  logic [6:0]  flags_d, flags_q;  // inf, snan, qnan, ine, ovf, unf, zero
  logic        dbz_d;
  pack_t       sel;
  logic        is_nan, is_inf, is_zero, use_pack;
  logic        spec_sign;

  always_comb begin
    is_nan    = 1'b0;
    is_inf    = 1'b0;
    is_zero   = 1'b0;
    use_pack  = 1'b0;
    spec_sign = 1'b0;
    dbz_d     = 1'b0;
    sel       = '0;
    out_d     = '0;
    flags_d   = '0;
    case (op_q)
      3'd0, 3'd1: begin
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign_eff))) begin
          is_nan = 1'b1;
        end else if (a_inf || b_inf) begin
          is_inf    = 1'b1;
          spec_sign = a_inf ? a_sign : b_sign_eff;
        end else if (a_zero && b_zero) begin
          is_zero   = 1'b1;
          spec_sign = (a_sign == b_sign_eff) ? a_sign : (rm_q == 2'd3);
        end else if (a_zero) begin
          out_d = {b_sign_eff, b_exp, b_frac};
        end else if (b_zero) begin
          out_d = opa_q;
        end else if (add_cancel) begin
          is_zero   = 1'b1;
          spec_sign = (rm_q == 2'd3);
        end else begin
          use_pack = 1'b1;
          sel      = add_p;
        end
        flags_d[5] = a_snan | b_snan;
      end
      3'd2: begin
        spec_sign = mul_sign;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
          is_nan = 1'b1;
        end else if (a_inf || b_inf) begin
          is_inf = 1'b1;
        end else if (a_zero || b_zero) begin
          is_zero = 1'b1;
        end else begin
          use_pack = 1'b1;
          sel      = mul_p;
        end
        flags_d[5] = a_snan | b_snan;
      end
`ifdef FPU_DIV_EN
      3'd3: begin
        spec_sign = mul_sign;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          is_nan = 1'b1;
        end else if (a_inf) begin
          is_inf = 1'b1;
        end else if (b_inf) begin
          is_zero = 1'b1;
        end else if (b_zero) begin
          is_inf = 1'b1;
          dbz_d  = 1'b1;
        end else if (a_zero) begin
          is_zero = 1'b1;
        end else begin
          use_pack = 1'b1;
          sel      = div_p;
        end
        flags_d[5] = a_snan | b_snan;
      end
`endif
      default: begin
        is_nan = 1'b1;
      end
    endcase

    if (is_nan) begin
      out_d      = QNAN;
      flags_d[4] = 1'b1;
    end else if (is_inf) begin
      out_d      = {spec_sign, 8'hFF, 23'h0};
      flags_d[6] = 1'b1;
    end else if (is_zero) begin
      out_d      = {spec_sign, 31'b0};
      flags_d[0] = 1'b1;
    end else if (use_pack) begin
      out_d      = sel.res;
      flags_d[6] = sel.inf;
      flags_d[3] = sel.ine;
      flags_d[2] = sel.ovf;
      flags_d[1] = sel.unf;
      flags_d[0] = sel.zero;
    end
  end

  // ---------------- stage 2: result registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

`ifdef FPU_DIV_EN
  logic dbz_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
  logic unused_dbz;
  assign unused_dbz = dbz_d;
`endif

  assign out       = out_q;
  assign inf       = flags_q[6];
  assign snan      = flags_q[5];
  assign qnan      = flags_q[4];
  assign ine       = flags_q[3];
  assign overflow  = flags_q[2];
  assign underflow = flags_q[1];
  assign zero      = flags_q[0];

endmodule

// File: tb/tb_fpu_core.sv
// tb_fpu_core: directed-vector bench for fpu_core. Each scenario task drives
// its own vectors and compares {flag_vector, out} against hand-computed values.
module tb_fpu_core;

  localparam logic [7:0] F_INF  = 8'h80;
  localparam logic [7:0] F_SNAN = 8'h40;
  localparam logic [7:0] F_QNAN = 8'h20;
  localparam logic [7:0] F_INE  = 8'h10;
  localparam logic [7:0] F_OVF  = 8'h08;
  localparam logic [7:0] F_UNF  = 8'h04;
  localparam logic [7:0] F_ZERO = 8'h02;
  localparam logic [7:0] F_DBZ  = 8'h01;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [2:0]  op;
    logic [7:0]  flags;
    logic [31:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic [1:0]  rmode = '0;
  logic [2:0]  fpu_op = '0;
  logic [31:0] out;
  logic        inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero;
  logic [39:0] dut_vec;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [39:0] exp_q[$];

  fpu_core #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opa(opa), .opb(opb), .rmode(rmode),
    .fpu_op(fpu_op), .out(out), .inf(inf), .snan(snan), .qnan(qnan),
    .ine(ine), .overflow(overflow), .underflow(underflow), .zero(zero),
    .div_by_zero(div_by_zero)
  );

  assign dut_vec = {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero, out};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] rm, input logic [2:0] op);
    opa = a; opb = b; rmode = rm; fpu_op = op;
  endtask

  // Called at a falling edge; returns at the falling edge where the result is stable.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [2:0] op);
    drive(a, b, rm, op);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(32'h3F80_0000, 32'h4000_0000, 2'd0, 3'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;  // asynchronous, mid-cycle, with a result in flight
    #1;
    vec_cnt++;
    if (dut_vec !== 40'h0) begin
      err_cnt++;
      $display("FAIL reset_async: got %h want %h", dut_vec, 40'h0);
    end
    drive(32'h4040_0000, 32'h3F00_0000, 2'd0, 3'd2);
    @(posedge clk);
    #1;
    vec_cnt++;
    if (dut_vec !== 40'h0) begin
      err_cnt++;
      $display("FAIL reset_held: got %h want %h", dut_vec, 40'h0);
    end
    @(negedge clk);
    drive(32'h3F80_0000, 32'h4000_0000, 2'd0, 3'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (out !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_lat1: got out %h want %h", out, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (dut_vec !== {8'h00, 32'h4040_0000}) begin
      err_cnt++;
      $display("FAIL reset_lat2: got %h want %h", dut_vec, {8'h00, 32'h4040_0000});
    end
  endtask

  task automatic test_add_mul();
    vec_t v [0:6];
    v[0] = {32'h3F80_0000, 32'h4000_0000, 2'd0, 3'd0, 8'h00,   32'h4040_0000};
    v[1] = {32'h4040_0000, 32'h3F00_0000, 2'd0, 3'd2, 8'h00,   32'h3FC0_0000};
    v[2] = {32'h3F80_0000, 32'h3F80_0000, 2'd3, 3'd1, F_ZERO,  32'h8000_0000};
    v[3] = {32'h3F80_0000, 32'h3F80_0000, 2'd0, 3'd1, F_ZERO,  32'h0000_0000};
    v[4] = {32'h8000_0000, 32'h8000_0000, 2'd0, 3'd0, F_ZERO,  32'h8000_0000};
    v[5] = {32'h4000_0000, 32'h3F00_0000, 2'd0, 3'd1, 8'h00,   32'h3FC0_0000};
    v[6] = {32'hC000_0000, 32'h4040_0000, 2'd0, 3'd2, 8'h00,   32'hC0C0_0000};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].a, v[i].b, v[i].rm, v[i].op);
      vec_cnt++;
      if (dut_vec !== {v[i].flags, v[i].res}) begin
        err_cnt++;
        $display("FAIL add_mul[%0d]: got %h want %h", i, dut_vec, {v[i].flags, v[i].res});
      end
    end
  endtask

  task automatic test_rounding();
    vec_t v [0:4];
    v[0] = {32'h3F80_0000, 32'h3380_0000, 2'd0, 3'd0, F_INE, 32'h3F80_0000};
    v[1] = {32'h3F80_0000, 32'h3380_0000, 2'd2, 3'd0, F_INE, 32'h3F80_0001};
    v[2] = {32'h3F80_0000, 32'h3380_0000, 2'd1, 3'd0, F_INE, 32'h3F80_0000};
    v[3] = {32'h3F80_0000, 32'h3380_0000, 2'd3, 3'd0, F_INE, 32'h3F80_0000};
    v[4] = {32'h3F80_0001, 32'h3380_0000, 2'd0, 3'd0, F_INE, 32'h3F80_0002};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].a, v[i].b, v[i].rm, v[i].op);
      vec_cnt++;
      if (dut_vec !== {v[i].flags, v[i].res}) begin
        err_cnt++;
        $display("FAIL rounding[%0d]: got %h want %h", i, dut_vec, {v[i].flags, v[i].res});
      end
    end
  endtask

  task automatic test_overflow_underflow();
    vec_t v [0:8];
    v[0] = {32'h7F7F_FFFF, 32'h4000_0000, 2'd0, 3'd2, F_INF | F_OVF | F_INE, 32'h7F80_0000};
    v[1] = {32'h7F7F_FFFF, 32'h4000_0000, 2'd1, 3'd2, F_OVF | F_INE,         32'h7F7F_FFFF};
    v[2] = {32'h7F7F_FFFF, 32'h4000_0000, 2'd2, 3'd2, F_INF | F_OVF | F_INE, 32'h7F80_0000};
    v[3] = {32'h7F7F_FFFF, 32'h4000_0000, 2'd3, 3'd2, F_OVF | F_INE,         32'h7F7F_FFFF};
    v[4] = {32'hFF7F_FFFF, 32'h4000_0000, 2'd2, 3'd2, F_OVF | F_INE,         32'hFF7F_FFFF};
    v[5] = {32'hFF7F_FFFF, 32'h4000_0000, 2'd3, 3'd2, F_INF | F_OVF | F_INE, 32'hFF80_0000};
    v[6] = {32'h0080_0000, 32'h3F00_0000, 2'd0, 3'd2, F_UNF | F_INE | F_ZERO, 32'h0000_0000};
    v[7] = {32'h0000_0001, 32'h3F80_0000, 2'd0, 3'd0, 8'h00,                 32'h3F80_0000};
    v[8] = {32'h7F80_0000, 32'h4000_0000, 2'd0, 3'd2, F_INF,                 32'h7F80_0000};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].a, v[i].b, v[i].rm, v[i].op);
      vec_cnt++;
      if (dut_vec !== {v[i].flags, v[i].res}) begin
        err_cnt++;
        $display("FAIL ovf_unf[%0d]: got %h want %h", i, dut_vec, {v[i].flags, v[i].res});
      end
    end
  endtask

  task automatic test_nan();
    vec_t v [0:4];
    v[0] = {32'h7F80_0001, 32'h3F80_0000, 2'd0, 3'd0, F_SNAN | F_QNAN, 32'h7FC0_0000};
    v[1] = {32'h7F80_0000, 32'h7F80_0000, 2'd0, 3'd1, F_QNAN,          32'h7FC0_0000};
    v[2] = {32'h0000_0000, 32'hFF80_0000, 2'd0, 3'd2, F_QNAN,          32'h7FC0_0000};
    v[3] = {32'h7FC0_0000, 32'h3F80_0000, 2'd0, 3'd2, F_QNAN,          32'h7FC0_0000};
    v[4] = {32'h3F80_0000, 32'h4000_0000, 2'd0, 3'd5, F_QNAN,          32'h7FC0_0000};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].a, v[i].b, v[i].rm, v[i].op);
      vec_cnt++;
      if (dut_vec !== {v[i].flags, v[i].res}) begin
        err_cnt++;
        $display("FAIL nan[%0d]: got %h want %h", i, dut_vec, {v[i].flags, v[i].res});
      end
    end
  endtask

  task automatic test_div();
`ifdef FPU_DIV_EN
    vec_t v [0:3];
    v[0] = {32'h3F80_0000, 32'h0000_0000, 2'd0, 3'd3, F_INF | F_DBZ, 32'h7F80_0000};
    v[1] = {32'h40C0_0000, 32'h4000_0000, 2'd0, 3'd3, 8'h00,         32'h4040_0000};
    v[2] = {32'h3F80_0000, 32'h4040_0000, 2'd0, 3'd3, F_INE,         32'h3EAA_AAAB};
    v[3] = {32'h0000_0000, 32'h0000_0000, 2'd0, 3'd3, F_QNAN,        32'h7FC0_0000};
    for (int i = 0; i < 4; i++) begin
`else
    vec_t v [0:0];
    v[0] = {32'h3F80_0000, 32'h0000_0000, 2'd0, 3'd3, F_QNAN, 32'h7FC0_0000};
    for (int i = 0; i < 1; i++) begin
`endif
      run_op(v[i].a, v[i].b, v[i].rm, v[i].op);
      vec_cnt++;
      if (dut_vec !== {v[i].flags, v[i].res}) begin
        err_cnt++;
        $display("FAIL div[%0d]: got %h want %h", i, dut_vec, {v[i].flags, v[i].res});
      end
    end
  endtask

  // One new op every cycle; results checked in order against the expected queue.
  task automatic test_back_to_back();
    vec_t v [0:4];
    logic [39:0] want;
    v[0] = {32'h3F80_0000, 32'h4000_0000, 2'd0, 3'd0, 8'h00,           32'h4040_0000};
    v[1] = {32'h4040_0000, 32'h3F00_0000, 2'd0, 3'd2, 8'h00,           32'h3FC0_0000};
    v[2] = {32'h3F80_0000, 32'h3380_0000, 2'd2, 3'd0, F_INE,           32'h3F80_0001};
    v[3] = {32'h7F80_0001, 32'h3F80_0000, 2'd0, 3'd0, F_SNAN | F_QNAN, 32'h7FC0_0000};
    v[4] = {32'h3F80_0000, 32'h3F80_0000, 2'd0, 3'd7, F_QNAN,          32'h7FC0_0000};
    for (int k = 0; k < 7; k++) begin
      if (k >= 2) begin
        want = exp_q.pop_front();
        vec_cnt++;
        if (dut_vec !== want) begin
          err_cnt++;
          $display("FAIL b2b[%0d]: got %h want %h", k - 2, dut_vec, want);
        end
      end
      if (k < 5) begin
        drive(v[k].a, v[k].b, v[k].rm, v[k].op);
        exp_q.push_back({v[k].flags, v[k].res});
      end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_mul();
    test_rounding();
    test_overflow_underflow();
    test_nan();
    test_div();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
